mem_master: RTL and testbench

Bus initiator for the parameterised single-port memory slave: the hardware counterpart of the program-based stimulus driver.
- Accepts read/write commands on a valid/ready command channel.
- Issues each command as one transfer on the memory bus (wr/addr/wdata/en, answered by response/rdata).
- Returns read data and a status code on a valid/ready result channel.
- Sits between a test sequencer or CPU-side agent and memory_rtl, in the top alongside memory_if.

---
 rtl/mem_master_pkg.sv | 21 ++
 rtl/mem_cmd_fifo.sv | 48 ++++
 rtl/mem_master.sv | 145 ++++++++++++++
 tb/tb_mem_master.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_master_pkg.sv
// rtl/mem_master_pkg.sv - shared FSM states, status codes and range helper for mem_master
package mem_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } state_e;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_ADDR_ERR = 2'b01;
  localparam logic [1:0] ST_TIMEOUT  = 2'b10;

  // Compared at 64 bits so a MEM_SIZE covering the whole address space never flags an error.
  function automatic logic addr_out_of_range(input longint unsigned addr,
                                             input longint unsigned mem_size);
    return addr >= mem_size;
  endfunction

endpackage

// File: rtl/mem_cmd_fifo.sv
// rtl/mem_cmd_fifo.sv - 2-entry command FIFO with push/pop/full/empty
module mem_cmd_fifo #(
  parameter int W = 41
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         push_ok;
  logic         pop_ok;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy; push and pop in one cycle leave occupancy unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/mem_master.sv
// rtl/mem_master.sv - command-driven bus initiator for the single-port memory slave
module mem_master
  import mem_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_rdata,
  output logic [1:0]            res_status,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_response,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] res_rdata_q, res_rdata_d;
  logic [1:0]            res_status_q, res_status_d;
  cmd_t                  fifo_din;
  cmd_t                  head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;

  assign fifo_din = '{wr: cmd_wr, addr: cmd_addr, wdata: cmd_wdata};

  mem_cmd_fifo #(.W($bits(cmd_t))) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (cmd_valid && cmd_ready),
    .din_i   (fifo_din),
    .pop_i   (fifo_pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Reset gates ready so every output reads 0 while reset is held.
  assign cmd_ready  = reset && !fifo_full;
  assign mem_en     = (state_q == ISSUE);
  assign res_valid  = (state_q == RESULT);
  assign mem_wr     = mem_wr_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign res_rdata  = res_rdata_q;
  assign res_status = res_status_q;

  // State, wait counter, held bus fields and the pending result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      res_rdata_q  <= '0;
      res_status_q <= ST_OK;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      res_rdata_q  <= res_rdata_d;
      res_status_q <= res_status_d;
    end
  end

  // Next state: pop and range-check, one-cycle strobe, wait with response priority, hand off result.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_wr_d     = mem_wr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    res_rdata_d  = res_rdata_q;
    res_status_d = res_status_q;
    fifo_pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (addr_out_of_range(64'(head.addr), 64'(MEM_SIZE))) begin
            res_status_d = ST_ADDR_ERR;
            res_rdata_d  = '0;
            state_d      = RESULT;
          end else begin
            mem_wr_d    = head.wr;
            mem_addr_d  = head.addr;
            mem_wdata_d = head.wdata;
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = 8'd0;
        state_d = WAIT;
      end
      WAIT: begin
        if (mem_response) begin
          res_status_d = ST_OK;
          res_rdata_d  = mem_wr_q ? '0 : mem_rdata;
          state_d      = RESULT;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          cnt_d        = cnt_q + 8'd1;
          res_status_d = ST_TIMEOUT;
          res_rdata_d  = '0;
          state_d      = RESULT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESULT: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_master.sv
// tb/tb_mem_master.sv - directed self-checking bench for mem_master
module tb_mem_master;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_rdata;
  logic [1:0]  res_status;
  logic        mem_en;
  logic        mem_wr;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_response;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  // slave model state
  int          slave_lat = 1;
  bit          slave_rand = 0;
  logic [31:0] smem [16];
  logic        s_wr;
  logic [7:0]  s_addr;
  int          s_lat;

  // mem_en monitor
  int   en_count = 0;
  int   en_long = 0;
  logic en_prev = 1'b0;

  mem_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MEM_SIZE(16), .TIMEOUT(15)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_wr       (cmd_wr),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_rdata    (res_rdata),
    .res_status   (res_status),
    .mem_en       (mem_en),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_response (mem_response),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mem_en === 1'b1) begin
        en_count++;
        if (en_prev === 1'b1) en_long++;
      end
      en_prev = mem_en;
    end
  end

  // memory slave: captures the strobe, answers after a programmable number of cycles
  initial begin
    mem_response = 1'b0;
    mem_rdata    = 32'h5A5A5A5A;
    for (int i = 0; i < 16; i++) smem[i] = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_en === 1'b1 && slave_lat >= 0) begin
        s_wr   = mem_wr;
        s_addr = mem_addr;
        s_lat  = slave_rand ? int'($urandom_range(1, 3)) : slave_lat;
        if (s_wr) smem[s_addr[3:0]] = mem_wdata;
        repeat (s_lat) @(posedge clk);
        #1;
        mem_response = 1'b1;
        mem_rdata    = s_wr ? 32'hBAD0BAD0 : smem[s_addr[3:0]];
        @(posedge clk);
        #1;
        mem_response = 1'b0;
        mem_rdata    = 32'h5A5A5A5A;
      end
    end
  end

  task automatic push_cmd(input logic wr, input logic [7:0] a, input logic [31:0] d);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL push_wait cmd_ready=%b required=1", cmd_ready);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic get_result(output logic [1:0] st, output logic [31:0] rd);
    int n = 0;
    res_ready = 1'b1;
    while (res_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (res_valid !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL result_wait res_valid=%b required=1", res_valid);
    end
    st = res_status;
    rd = res_rdata;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  task automatic measure(output int k);
    int n = 0;
    k = -1;
    while (mem_en !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (mem_en === 1'b1) begin
      k = 0;
      while (res_valid !== 1'b1 && k < 40) begin
        @(negedge clk);
        k++;
      end
    end
  endtask

  task automatic test_reset;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = 8'h0;
    cmd_wdata = 32'h0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({cmd_ready, res_valid, mem_en, mem_wr} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ctrl got=%b required=0000", {cmd_ready, res_valid, mem_en, mem_wr});
    end
    n_cmp++;
    if ({res_status, res_rdata, mem_addr, mem_wdata} !== 74'h0) begin
      n_err++;
      $display("FAIL reset_data got=%h required=0", {res_status, res_rdata, mem_addr, mem_wdata});
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready_after got=%b required=1", cmd_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read;
    logic [1:0]  st;
    logic [31:0] rd;
    int          e0;
    slave_lat = 1;
    e0 = en_count;
    push_cmd(1'b1, 8'd3, 32'hDEADBEEF);
    get_result(st, rd);
    n_cmp++;
    if ({st, rd} !== {2'b00, 32'h0}) begin
      n_err++;
      $display("FAIL write_result got=%b/%h required=00/00000000", st, rd);
    end
    push_cmd(1'b0, 8'd3, 32'h0);
    get_result(st, rd);
    n_cmp++;
    if ({st, rd} !== {2'b00, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL read_result got=%b/%h required=00/deadbeef", st, rd);
    end
    n_cmp++;
    if (en_count - e0 !== 2 || en_long !== 0) begin
      n_err++;
      $display("FAIL en_pulses got=%0d long=%0d required=2 long=0", en_count - e0, en_long);
    end
    n_cmp++;
    if (smem[3] !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL bus_write_data got=%h required=deadbeef", smem[3]);
    end
  endtask

  task automatic test_addr_err;
    logic [1:0]  st;
    logic [31:0] rd;
    int          e0;
    e0 = en_count;
    push_cmd(1'b0, 8'd16, 32'h0);
    get_result(st, rd);
    n_cmp++;
    if ({st, rd} !== {2'b01, 32'h0}) begin
      n_err++;
      $display("FAIL addr_err_result got=%b/%h required=01/00000000", st, rd);
    end
    push_cmd(1'b1, 8'hFF, 32'h12345678);
    get_result(st, rd);
    n_cmp++;
    if ({st, rd} !== {2'b01, 32'h0}) begin
      n_err++;
      $display("FAIL addr_err_max got=%b/%h required=01/00000000", st, rd);
    end
    n_cmp++;
    if (en_count !== e0) begin
      n_err++;
      $display("FAIL addr_err_no_bus got=%0d required=%0d", en_count, e0);
    end
  endtask

  task automatic test_timeout;
    logic [1:0]  st;
    logic [31:0] rd;
    int          k;
    slave_lat = -1;
    push_cmd(1'b0, 8'd5, 32'h0);
    measure(k);
    n_cmp++;
    if (k !== 16) begin
      n_err++;
      $display("FAIL timeout_latency got=%0d required=16", k);
    end
    get_result(st, rd);
    n_cmp++;
    if ({st, rd} !== {2'b10, 32'h0}) begin
      n_err++;
      $display("FAIL timeout_result got=%b/%h required=10/00000000", st, rd);
    end
    slave_lat = 15;
    push_cmd(1'b0, 8'd3, 32'h0);
    measure(k);
    n_cmp++;
    if (k !== 16) begin
      n_err++;
      $display("FAIL last_cycle_latency got=%0d required=16", k);
    end
    get_result(st, rd);
    n_cmp++;
    if ({st, rd} !== {2'b00, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL last_cycle_resp got=%b/%h required=00/deadbeef", st, rd);
    end
    slave_lat = 16;
    push_cmd(1'b0, 8'd3, 32'h0);
    measure(k);
    get_result(st, rd);
    n_cmp++;
    if ({st, rd} !== {2'b10, 32'h0}) begin
      n_err++;
      $display("FAIL late_resp_ignored got=%b/%h required=10/00000000", st, rd);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (res_valid !== 1'b0) begin
      n_err++;
      $display("FAIL late_resp_no_result got=%b required=0", res_valid);
    end
  endtask

  task automatic test_backpressure;
    logic [1:0]  st;
    logic [31:0] rd;
    slave_lat = 1;
    res_ready = 1'b0;
    push_cmd(1'b1, 8'd1, 32'h11111111);
    push_cmd(1'b1, 8'd2, 32'h22222222);
    push_cmd(1'b0, 8'd1, 32'h0);
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_ready_low got=%b required=0", cmd_ready);
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({res_valid, res_status, res_rdata, cmd_ready} !== {1'b1, 2'b00, 32'h0, 1'b0}) begin
        n_err++;
        $display("FAIL bp_hold%0d got=%b/%b/%h/%b required=1/00/00000000/0",
                 i, res_valid, res_status, res_rdata, cmd_ready);
      end
      @(negedge clk);
    end
    get_result(st, rd);
    n_cmp++;
    if ({st, rd} !== {2'b00, 32'h0}) begin
      n_err++;
      $display("FAIL bp_res0 got=%b/%h required=00/00000000", st, rd);
    end
    get_result(st, rd);
    n_cmp++;
    if ({st, rd} !== {2'b00, 32'h0}) begin
      n_err++;
      $display("FAIL bp_res1 got=%b/%h required=00/00000000", st, rd);
    end
    get_result(st, rd);
    n_cmp++;
    if ({st, rd} !== {2'b00, 32'h11111111}) begin
      n_err++;
      $display("FAIL bp_res2 got=%b/%h required=00/11111111", st, rd);
    end
    n_cmp++;
    if (cmd_ready !== 1'b1 || smem[2] !== 32'h22222222) begin
      n_err++;
      $display("FAIL bp_drained ready=%b mem2=%h required=1/22222222", cmd_ready, smem[2]);
    end
  endtask

  task automatic test_reset_mid_wait;
    logic [1:0]  st;
    logic [31:0] rd;
    int          e0;
    int          stale;
    int          n;
    slave_lat = -1;
    push_cmd(1'b0, 8'd4, 32'hCAFEF00D);
    push_cmd(1'b1, 8'd5, 32'h55555555);
    n = 0;
    while (mem_en !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({mem_addr, mem_wdata} !== {8'd4, 32'hCAFEF00D}) begin
      n_err++;
      $display("FAIL wait_hold got=%h/%h required=04/cafef00d", mem_addr, mem_wdata);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({mem_en, mem_wr, mem_addr, mem_wdata, cmd_ready, res_valid} !== 44'h0) begin
      n_err++;
      $display("FAIL async_reset_outputs got=%h required=0",
               {mem_en, mem_wr, mem_addr, mem_wdata, cmd_ready, res_valid});
    end
    repeat (2) @(negedge clk);
    e0 = en_count;
    reset = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (res_valid !== 1'b0) stale++;
    end
    n_cmp++;
    if (stale !== 0 || en_count !== e0) begin
      n_err++;
      $display("FAIL flush_after_reset stale=%0d en=%0d required=0/%0d", stale, en_count, e0);
    end
    @(posedge clk);
    #1;
    slave_lat = 1;
    push_cmd(1'b1, 8'd0, 32'h0BADF00D);
    get_result(st, rd);
    n_cmp++;
    if ({st, rd, smem[0]} !== {2'b00, 32'h0, 32'h0BADF00D}) begin
      n_err++;
      $display("FAIL post_reset_write got=%b/%h mem0=%h required=00/00000000/0badf00d", st, rd, smem[0]);
    end
  endtask

  task automatic test_random_stream;
    logic [31:0] ref_mem [16];
    logic [1:0]  st;
    logic [31:0] rd;
    logic [1:0]  exp_st;
    logic [31:0] exp_rd;
    logic        wr;
    logic [7:0]  a;
    logic [31:0] d;
    int          e0;
    int          in_range;
    for (int i = 0; i < 16; i++) begin
      smem[i]    = 32'h10000000 + 32'(i);
      ref_mem[i] = 32'h10000000 + 32'(i);
    end
    slave_rand = 1'b1;
    slave_lat  = 1;
    e0         = en_count;
    in_range   = 0;
    for (int i = 0; i < 200; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 17));
      d  = $urandom;
      if (a >= 8'd16) begin
        exp_st = 2'b01;
        exp_rd = 32'h0;
      end else begin
        in_range++;
        exp_st = 2'b00;
        if (wr) begin
          exp_rd           = 32'h0;
          ref_mem[a[3:0]]  = d;
        end else begin
          exp_rd = ref_mem[a[3:0]];
        end
      end
      push_cmd(wr, a, d);
      get_result(st, rd);
      n_cmp++;
      if ({st, rd} !== {exp_st, exp_rd}) begin
        n_err++;
        $display("FAIL rand%0d wr=%b a=%0d got=%b/%h required=%b/%h", i, wr, a, st, rd, exp_st, exp_rd);
      end
    end
    slave_rand = 1'b0;
    n_cmp++;
    if (en_count - e0 !== in_range) begin
      n_err++;
      $display("FAIL rand_bus_count got=%0d required=%0d", en_count - e0, in_range);
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_addr_err;
    test_timeout;
    test_backpressure;
    test_reset_mid_wait;
    test_random_stream;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
